switch_arbiter: RTL and testbench

SWITCH_ARBITER -- requirements
Module: switch_arbiter

---
 rtl/switch_arbiter.sv | 114 +++++++++++
 tb/tb_switch_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_arbiter.sv
// 4-port crossbar arbiter: each output runs its own round-robin search over the
// input ports, grants are registered, and a per-port holdoff masks popped FIFOs.
module switch_arbiter #(
  parameter int HOLDOFF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arb_en,
  input  logic [3:0] req,
  input  logic [3:0] pkt_dst0,
  input  logic [3:0] pkt_dst1,
  input  logic [3:0] pkt_dst2,
  input  logic [3:0] pkt_dst3,
  output logic [3:0] grant,
  output logic [3:0] out_valid,
  output logic [1:0] out_sel0,
  output logic [1:0] out_sel1,
  output logic [1:0] out_sel2,
  output logic [1:0] out_sel3,
  output logic [3:0] dst_err
);

  localparam logic [1:0] HOLD_LOAD = 2'(HOLDOFF);

  logic [3:0] dst [4];
  logic [1:0] rr_ptr [4];
  logic [1:0] sel_q [4];
  logic [1:0] hold_cnt [4];
  logic [1:0] sel_port [4];
  logic [3:0] dst_ok;
  logic [3:0] masked;
  logic [3:0] sel_valid;
  logic [3:0] grant_next;
  logic [1:0] idx;
  logic       found;
  logic [1:0] pick;

  assign dst[0]   = pkt_dst0;
  assign dst[1]   = pkt_dst1;
  assign dst[2]   = pkt_dst2;
  assign dst[3]   = pkt_dst3;
  assign out_sel0 = sel_q[0];
  assign out_sel1 = sel_q[1];
  assign out_sel2 = sel_q[2];
  assign out_sel3 = sel_q[3];

  // A port is masked while its grant is on the bus and while its holdoff runs.
  always_comb begin
    dst_ok = 4'b0;
    masked = 4'b0;
    for (int p = 0; p < 4; p++) begin
      dst_ok[p] = (dst[p] != 4'b0) && ((dst[p] & (dst[p] - 4'd1)) == 4'b0);
      masked[p] = grant[p] || (hold_cnt[p] != 2'd0);
    end
  end

  // Round-robin search per output, starting at that output's pointer.
  always_comb begin
    idx        = 2'd0;
    found      = 1'b0;
    pick       = 2'd0;
    sel_valid  = 4'b0;
    grant_next = 4'b0;
    for (int o = 0; o < 4; o++) begin
      sel_port[o] = 2'd0;
    end
    for (int o = 0; o < 4; o++) begin
      found = 1'b0;
      pick  = 2'd0;
      for (int k = 0; k < 4; k++) begin
        idx = rr_ptr[o] + 2'(k);
        if (!found && arb_en && req[idx] && dst_ok[idx] && !masked[idx] && dst[idx][o]) begin
          found = 1'b1;
          pick  = idx;
        end
      end
      sel_valid[o] = found;
      sel_port[o]  = pick;
      if (found) begin
        grant_next[pick] = 1'b1;
      end
    end
  end

  // Holdoff is loaded during the grant cycle so the mask covers HOLDOFF more cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant     <= 4'b0;
      out_valid <= 4'b0;
      dst_err   <= 4'b0;
      for (int i = 0; i < 4; i++) begin
        rr_ptr[i]   <= 2'd0;
        sel_q[i]    <= 2'd0;
        hold_cnt[i] <= 2'd0;
      end
    end else begin
      grant     <= grant_next;
      out_valid <= sel_valid;
      dst_err   <= req & ~dst_ok & ~masked;
      for (int i = 0; i < 4; i++) begin
        if (sel_valid[i]) begin
          sel_q[i]  <= sel_port[i];
          rr_ptr[i] <= sel_port[i] + 2'd1;
        end
        if (grant[i]) begin
          hold_cnt[i] <= HOLD_LOAD;
        end else if (hold_cnt[i] != 2'd0) begin
          hold_cnt[i] <= hold_cnt[i] - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_arbiter.sv
// Bench for switch_arbiter: directed vector table, hand sequences for the
// multi-cycle corners, then random traffic against a timestamp-based model.
module tb_switch_arbiter;

  localparam int HOLDOFF = 1;

  logic       clk;
  logic       rst;
  logic       arb_en;
  logic [3:0] req;
  logic [3:0] pkt_dst0, pkt_dst1, pkt_dst2, pkt_dst3;
  logic [3:0] grant;
  logic [3:0] out_valid;
  logic [1:0] out_sel0, out_sel1, out_sel2, out_sel3;
  logic [3:0] dst_err;

  int checks = 0;
  int errors = 0;

  switch_arbiter #(.HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en), .req(req),
    .pkt_dst0(pkt_dst0), .pkt_dst1(pkt_dst1), .pkt_dst2(pkt_dst2), .pkt_dst3(pkt_dst3),
    .grant(grant), .out_valid(out_valid),
    .out_sel0(out_sel0), .out_sel1(out_sel1), .out_sel2(out_sel2), .out_sel3(out_sel3),
    .dst_err(dst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [15:0] dst;
    logic [3:0]  exp_grant;
    logic [3:0]  exp_valid;
    logic [3:0]  exp_err;
    logic [7:0]  exp_sel;
  } vec_t;

  vec_t vecs [11];

  // Reference model: round-robin pointers plus the cycle each port's grant is visible.
  int         cyc;
  int         m_ptr [4];
  int         m_last [4];
  logic [3:0] exp_grant, exp_valid, exp_err;
  logic [1:0] exp_sel [4];

  function automatic bit model_masked(int p);
    return (cyc >= m_last[p]) && (cyc <= m_last[p] + HOLDOFF);
  endfunction

  task automatic check_eq(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] dut_sel();
    return {out_sel3, out_sel2, out_sel1, out_sel0};
  endfunction

  task automatic check_output();
    check_eq("model_grant", {4'b0, grant}, {4'b0, exp_grant});
    check_eq("model_out_valid", {4'b0, out_valid}, {4'b0, exp_valid});
    check_eq("model_dst_err", {4'b0, dst_err}, {4'b0, exp_err});
    check_eq("model_out_sel", dut_sel(), {exp_sel[3], exp_sel[2], exp_sel[1], exp_sel[0]});
  endtask

  // Drive one cycle of inputs, predict the next outputs, then compare after the edge.
  task automatic apply_stimulus(input logic r, input logic e, input logic [3:0] rq,
                                input logic [15:0] d);
    bit         mk [4];
    logic [3:0] dv;
    int         p;
    rst      = r;
    arb_en   = e;
    req      = rq;
    pkt_dst0 = d[3:0];
    pkt_dst1 = d[7:4];
    pkt_dst2 = d[11:8];
    pkt_dst3 = d[15:12];
    exp_grant = 4'b0;
    exp_valid = 4'b0;
    exp_err   = 4'b0;
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        m_ptr[i]   = 0;
        m_last[i]  = -100;
        exp_sel[i] = 2'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        mk[i] = model_masked(i);
        dv    = d[4*i +: 4];
        if (rq[i] && !mk[i] && ($countones(dv) != 1)) exp_err[i] = 1'b1;
      end
      for (int o = 0; o < 4; o++) begin
        for (int k = 0; k < 4; k++) begin
          p  = (m_ptr[o] + k) % 4;
          dv = d[4*p +: 4];
          if (!exp_valid[o] && e && rq[p] && !mk[p] && ($countones(dv) == 1) && dv[o]) begin
            exp_valid[o] = 1'b1;
            exp_grant[p] = 1'b1;
            exp_sel[o]   = 2'(p);
            m_ptr[o]     = (p + 1) % 4;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (exp_grant[i]) m_last[i] = cyc + 1;
      end
    end
    cyc++;
    @(negedge clk);
    check_output();
  endtask

  logic        r_rst, r_en;
  logic [3:0]  r_req;
  logic [15:0] r_dst;

  initial begin
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      m_ptr[i]   = 0;
      m_last[i]  = -100;
      exp_sel[i] = 2'd0;
    end

    vecs[0]  = '{1'b1, 1'b1, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 4'h1, 16'h0004, 4'h1, 4'h4, 4'h0, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 8'h00};
    vecs[4]  = '{1'b0, 1'b1, 4'hf, 16'h8421, 4'hf, 4'hf, 4'h0, 8'he4};
    vecs[5]  = '{1'b0, 1'b1, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 8'he4};
    vecs[6]  = '{1'b0, 1'b1, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 8'he4};
    vecs[7]  = '{1'b0, 1'b1, 4'h2, 16'h0060, 4'h0, 4'h0, 4'h2, 8'he4};
    vecs[8]  = '{1'b0, 1'b1, 4'h2, 16'h0060, 4'h0, 4'h0, 4'h2, 8'he4};
    vecs[9]  = '{1'b0, 1'b1, 4'h2, 16'h0020, 4'h2, 4'h2, 4'h0, 8'he4};
    vecs[10] = '{1'b0, 1'b1, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 8'he4};

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].dst);
      check_eq($sformatf("tbl%0d_grant", i), {4'b0, grant}, {4'b0, vecs[i].exp_grant});
      check_eq($sformatf("tbl%0d_valid", i), {4'b0, out_valid}, {4'b0, vecs[i].exp_valid});
      check_eq($sformatf("tbl%0d_err", i), {4'b0, dst_err}, {4'b0, vecs[i].exp_err});
      check_eq($sformatf("tbl%0d_sel", i), dut_sel(), vecs[i].exp_sel);
    end

    // All four ports contend for output 0: rotation 0,1,2,3,0.
    apply_stimulus(1'b1, 1'b1, 4'h0, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 1'b1, 4'hf, 16'h1111);
      check_eq($sformatf("rr%0d_grant", i), {4'b0, grant}, 8'(4'b0001 << (i % 4)));
      check_eq($sformatf("rr%0d_valid", i), {4'b0, out_valid}, 8'h01);
      check_eq($sformatf("rr%0d_sel0", i), {6'b0, out_sel0}, 8'(i % 4));
    end

    // Pointer wrap on output 1, then arbitration disabled for five cycles.
    apply_stimulus(1'b1, 1'b1, 4'h0, 16'h0000);
    apply_stimulus(1'b0, 1'b1, 4'b0100, 16'h0200);
    check_eq("wrap_setup_grant", {4'b0, grant}, 8'h04);
    apply_stimulus(1'b0, 1'b1, 4'h0, 16'h0000);
    apply_stimulus(1'b0, 1'b1, 4'b1001, 16'h2002);
    check_eq("wrap_grant", {4'b0, grant}, 8'h08);
    check_eq("wrap_sel1", {6'b0, out_sel1}, 8'h03);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 1'b0, 4'b1001, 16'h2002);
      check_eq($sformatf("dis%0d_grant", i), {4'b0, grant}, 8'h00);
    end
    apply_stimulus(1'b0, 1'b1, 4'b1001, 16'h2002);
    check_eq("reen_grant", {4'b0, grant}, 8'h01);
    check_eq("reen_sel1", {6'b0, out_sel1}, 8'h00);

    // Reset during a grant cycle clears outputs and pointers.
    apply_stimulus(1'b0, 1'b1, 4'b0100, 16'h0800);
    check_eq("pre_rst_sel3", {6'b0, out_sel3}, 8'h02);
    apply_stimulus(1'b1, 1'b1, 4'b0100, 16'h0800);
    check_eq("rst_grant", {4'b0, grant}, 8'h00);
    check_eq("rst_valid", {4'b0, out_valid}, 8'h00);
    check_eq("rst_sel", dut_sel(), 8'h00);
    apply_stimulus(1'b0, 1'b1, 4'b1001, 16'h8008);
    check_eq("post_rst_grant", {4'b0, grant}, 8'h01);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r_rst = ($urandom_range(0, 49) == 0);
      r_en  = ($urandom_range(0, 9) != 0);
      r_req = 4'($urandom);
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(0, 3) != 0) r_dst[4*p +: 4] = 4'(1 << $urandom_range(0, 3));
        else                           r_dst[4*p +: 4] = 4'($urandom_range(0, 15));
      end
      apply_stimulus(r_rst, r_en, r_req, r_dst);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
